// File: rtl/bfs_axi_read_arbiter_pkg.sv
// Shared definitions for the BFS AXI read arbiter: FSM encoding and AXI response codes.
package bfs_axi_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bfs_rr_pick.sv
// Round-robin pick: first requester above last_i (with wrap) whose request bit is set.
module bfs_rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  always_comb begin
    logic [IW-1:0] cand;
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= int'(N); k++) begin
      cand = IW'((int'(last_i) + k) % int'(N));
      if (!found_o && req_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bfs_axi_read_arbiter.sv
// Arbitrates NUM_REQ burst readers onto one AXI read port, one burst in flight,
// with zero-latency R-channel routing to the owner and a sticky error flag.
module bfs_axi_read_arbiter
  import bfs_axi_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]              req_len,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [AXI_DATA_WIDTH-1:0]         rsp_data,
  output logic                              rsp_last,
  output logic [NUM_REQ-1:0]                rsp_valid,
  input  logic [NUM_REQ-1:0]                rsp_ready,
  output logic [AXI_ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                        m_axi_arlen,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic                              m_axi_rlast,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready,
  output logic                              err_sticky,
  input  logic                              err_clear,
  output logic                              busy
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  state_e                    state_q;
  logic [IW-1:0]             last_grant_q;
  logic [IW-1:0]             grant_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic [7:0]                beat_cnt_q;
  logic                      err_q;

  logic [AXI_ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [7:0]                len_arr  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
    assign len_arr[gi]  = req_len[gi*8 +: 8];
  end

  logic [IW-1:0] pick_idx;
  logic          pick_found;

  bfs_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i   (req_valid),
    .last_i  (last_grant_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  logic in_idle, in_data, grant, beat_acc, err_set;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_data  = (state_q == ST_DATA);
  assign grant    = in_idle & pick_found;
  assign beat_acc = in_data & m_axi_rvalid & m_axi_rready;
  // beat_cnt_q holds the beats before this one, so a correct rlast sees exactly len.
  assign err_set  = beat_acc & ((m_axi_rresp != RESP_OKAY) |
                                (m_axi_rlast & (beat_cnt_q != len_q)));

  always_comb begin
    req_ready    = grant ? (NUM_REQ'(1) << pick_idx) : '0;
    rsp_valid    = (in_data & m_axi_rvalid) ? (NUM_REQ'(1) << grant_q) : '0;
    m_axi_rready = in_data & rsp_ready[grant_q];
    rsp_data     = in_data ? m_axi_rdata : '0;
    rsp_last     = in_data & m_axi_rlast;
  end

  assign m_axi_arvalid = (state_q == ST_ADDR);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign err_sticky    = err_q;
  assign busy          = ~in_idle;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      grant_q      <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      // A set in the same cycle as a clear wins.
      err_q <= err_set | (err_q & ~err_clear);
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            grant_q    <= pick_idx;
            addr_q     <= addr_arr[pick_idx];
            len_q      <= len_arr[pick_idx];
            beat_cnt_q <= '0;
            state_q    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_axi_arready) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (beat_acc) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (m_axi_rlast) begin
              state_q      <= ST_IDLE;
              last_grant_q <= grant_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bfs_axi_read_arbiter.sv
// Self-checking bench: transaction-level arbiter model + AXI slave responder + directed scenarios.
module tb_bfs_axi_read_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 64;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*8-1:0]  req_len;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_last;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic            m_axi_arvalid;
  logic            m_axi_arready;
  logic [DW-1:0]   m_axi_rdata;
  logic            m_axi_rlast;
  logic [1:0]      m_axi_rresp;
  logic            m_axi_rvalid;
  logic            m_axi_rready;
  logic            err_sticky;
  logic            err_clear;
  logic            busy;

  always #5 aclk = ~aclk;

  bfs_axi_read_arbiter #(
    .NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .err_sticky(err_sticky), .err_clear(err_clear), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_phase;   // 0 idle, 1 address, 2 data
  int          m_last;
  int          m_g;
  int          m_beat;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic        m_err;

  function automatic int rr(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_req_ready();
    logic [N-1:0] one;
    int w;
    one = 1;
    if (m_phase != 0) return '0;
    w = rr(m_last, req_valid);
    if (w < 0) return '0;
    return one << w;
  endfunction

  logic m_beat_ok;
  logic m_err_set;
  assign m_beat_ok = (m_phase == 2) && m_axi_rvalid && rsp_ready[m_g];
  // Error: non-OKAY beat, or burst ended with a total beat count other than len+1.
  assign m_err_set = m_beat_ok && ((m_axi_rresp != 2'b00) ||
                     (m_axi_rlast && ((m_beat + 1) != (int'(m_len) + 1))));

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_phase <= 0; m_last <= N - 1; m_g <= 0; m_beat <= 0;
      m_addr <= '0; m_len <= '0; m_err <= 1'b0;
    end else begin
      m_err <= (m_err && !err_clear) || m_err_set;
      case (m_phase)
        0: if (rr(m_last, req_valid) >= 0) begin
             m_g     <= rr(m_last, req_valid);
             m_addr  <= req_addr[rr(m_last, req_valid)*AW +: AW];
             m_len   <= req_len[rr(m_last, req_valid)*8 +: 8];
             m_beat  <= 0;
             m_phase <= 1;
           end
        1: if (m_axi_arready) m_phase <= 2;
        default: if (m_beat_ok) begin
             m_beat <= m_beat + 1;
             if (m_axi_rlast) begin
               m_phase <= 0;
               m_last  <= m_g;
             end
           end
      endcase
    end
  end

  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- per-cycle compare ----------------
  int gq[$];
  int gcyc[$];
  int beats[N];
  int ar_hi = 0;

  always @(negedge aclk) begin
    if (aresetn) begin
      chk("req_ready", 64'(req_ready), 64'(exp_req_ready()));
      chk("busy", 64'(busy), 64'(m_phase != 0));
      chk("arvalid", 64'(m_axi_arvalid), 64'(m_phase == 1));
      if (m_phase == 1) begin
        chk("araddr", 64'(m_axi_araddr), 64'(m_addr));
        chk("arlen", 64'(m_axi_arlen), 64'(m_len));
      end
      chk("rready", 64'(m_axi_rready), 64'((m_phase == 2) ? rsp_ready[m_g] : 1'b0));
      chk("rsp_valid", 64'(rsp_valid),
          64'(((m_phase == 2) && m_axi_rvalid) ? (1 << m_g) : 0));
      if ((m_phase == 2) && m_axi_rvalid) begin
        chk("rsp_data", rsp_data, m_axi_rdata);
        chk("rsp_last", 64'(rsp_last), 64'(m_axi_rlast));
      end
      if (m_beat_ok) begin
        chk("beat_payload", rsp_data, {m_addr, 32'(m_beat)});
        beats[m_g]++;
      end
      chk("err_sticky", 64'(err_sticky), 64'(m_err));
      if (exp_req_ready() != 0) begin
        gq.push_back(rr(m_last, req_valid));
        gcyc.push_back(cyc);
      end
      if (m_axi_arvalid) ar_hi++;
    end
  end

  // ---------------- AXI slave responder ----------------
  int          ar_wait = 0;
  int          force_beats = 0;
  int          err_beat = -1;
  bit          gap_mode = 1'b0;
  bit          rdy_toggle = 1'b0;
  int          s_phase = 0;
  int          s_beat = 0;
  int          wait_cnt = 0;
  int          pat = 0;
  int          nb;
  logic [31:0] s_addr = '0;
  logic [7:0]  s_len = '0;
  logic        hs_ar, hs_r, lst, arv;
  logic [31:0] cap_addr;
  logic [7:0]  cap_len;

  initial begin
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    m_axi_rresp = 2'b00; m_axi_rdata = '0; rsp_ready = '1;
    forever begin
      @(negedge aclk);
      hs_ar = m_axi_arvalid && m_axi_arready;
      hs_r  = m_axi_rvalid && m_axi_rready;
      lst   = m_axi_rlast;
      arv   = m_axi_arvalid;
      cap_addr = m_axi_araddr;
      cap_len  = m_axi_arlen;
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        s_phase = 0; wait_cnt = 0; s_beat = 0;
        m_axi_arready = (ar_wait == 0);
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
        rsp_ready = '1;
      end else begin
        if (s_phase == 0) begin
          if (hs_ar) begin
            s_phase = 1; s_beat = 0; wait_cnt = 0; s_addr = cap_addr; s_len = cap_len;
          end else if (arv) begin
            wait_cnt++;
          end
        end else if (hs_r) begin
          s_beat++;
          if (lst) begin
            s_phase = 0; wait_cnt = 0;
          end
        end
        m_axi_arready = (s_phase == 0) && (wait_cnt >= ar_wait);
        if (s_phase == 1) begin
          if (!(m_axi_rvalid && !hs_r)) m_axi_rvalid = gap_mode ? ((pat % 3) != 0) : 1'b1;
          nb = (force_beats > 0) ? force_beats : int'(s_len) + 1;
          m_axi_rdata = {s_addr, 32'(s_beat)};
          m_axi_rlast = (s_beat == nb - 1);
          m_axi_rresp = (s_beat == err_beat) ? 2'b10 : 2'b00;
        end else begin
          m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
        end
        rsp_ready = rdy_toggle ? (pat[0] ? '1 : '0) : '1;
        pat++;
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_grant();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (req_ready != 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("grant_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 64'(ok), 64'd1);
  endtask

  task automatic do_burst(input logic [N-1:0] mask);
    @(posedge aclk); #1 req_valid = mask;
    wait_grant();
    @(posedge aclk); #1 req_valid = '0;
    wait_idle();
  endtask

  task automatic clear_err();
    @(posedge aclk); #1 err_clear = 1'b1;
    @(posedge aclk); #1 err_clear = 1'b0;
    @(negedge aclk);
    chk("err_cleared", 64'(err_sticky), 64'd0);
  endtask

  task automatic clear_stats();
    gq.delete(); gcyc.delete(); ar_hi = 0;
    for (int i = 0; i < N; i++) beats[i] = 0;
  endtask

  initial begin
    logic ok;
    req_valid = '0;
    req_addr  = {32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    req_len   = {8'd0, 8'd3, 8'd1};
    err_clear = 1'b0;
    for (int i = 0; i < N; i++) beats[i] = 0;

    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst_araddr", 64'(m_axi_araddr), 64'd0);
    chk("rst_rready", 64'(m_axi_rready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_err", 64'(err_sticky), 64'd0);

    // Fairness: all three request continuously for six bursts.
    @(posedge aclk); #1 req_valid = 3'b111;
    @(negedge aclk);
    chk("first_grant", 64'(req_ready), 64'b001);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (gq.size() >= 6) begin
        ok = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    chk("six_grants", 64'(ok), 64'd1);
    @(posedge aclk); #1 req_valid = '0;
    wait_idle();
    for (int i = 0; i < 6 && i < gq.size(); i++) begin
      chk("grant_order", 64'(gq[i]), 64'(i % 3));
      $display("grant %0d -> requester %0d", i, gq[i]);
    end
    chk("beats_r0", 64'(beats[0]), 64'd4);
    chk("beats_r1", 64'(beats[1]), 64'd8);
    chk("beats_r2", 64'(beats[2]), 64'd2);

    // Back-to-back grants for a lone requester (len 1): grant spacing 4 cycles.
    clear_stats();
    @(posedge aclk); #1 req_valid = 3'b001;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (gq.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk); #1 req_valid = '0;
    wait_idle();
    chk("b2b_grants", 64'(ok), 64'd1);
    if (gcyc.size() >= 2) chk("b2b_gap", 64'(gcyc[1] - gcyc[0]), 64'd4);

    // AR hold: arready low 5 cycles, requester 1 at 0x1000 len 3.
    clear_stats();
    ar_wait = 5;
    do_burst(3'b010);
    ar_wait = 0;
    $display("ar hold: arvalid cycles %0d, beats r1=%0d", ar_hi, beats[1]);
    chk("ar_hold_cycles", 64'(ar_hi), 64'd6);
    chk("ar_beats_r1", 64'(beats[1]), 64'd4);
    chk("ar_beats_r0", 64'(beats[0]), 64'd0);
    chk("ar_beats_r2", 64'(beats[2]), 64'd0);

    // Backpressure: rsp_ready toggling, rvalid gapped, requester 2 len 2.
    clear_stats();
    req_len[23:16] = 8'd2;
    rdy_toggle = 1'b1; gap_mode = 1'b1;
    do_burst(3'b100);
    rdy_toggle = 1'b0; gap_mode = 1'b0;
    $display("backpressure: beats r2=%0d", beats[2]);
    chk("bp_beats_r2", 64'(beats[2]), 64'd3);

    // SLVERR on beat 2 of a 4-beat burst.
    req_len[7:0] = 8'd3;
    err_beat = 2;
    do_burst(3'b001);
    err_beat = -1;
    chk("slverr_set", 64'(err_sticky), 64'd1);
    repeat (3) @(negedge aclk);
    chk("slverr_sticky", 64'(err_sticky), 64'd1);
    clear_err();

    // Early rlast: 2 beats delivered for len 3.
    force_beats = 2;
    do_burst(3'b010);
    force_beats = 0;
    chk("short_burst_err", 64'(err_sticky), 64'd1);
    clear_err();

    // err_clear held while an erroring beat is accepted.
    req_len[23:16] = 8'd0;
    err_beat = 0;
    @(posedge aclk); #1 req_valid = 3'b100; err_clear = 1'b1;
    wait_grant();
    @(posedge aclk); #1 req_valid = '0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (rsp_valid[2] && rsp_ready[2]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("coinc_beat_seen", 64'(ok), 64'd1);
    @(posedge aclk); #1 err_clear = 1'b0; err_beat = -1;
    @(negedge aclk);
    chk("coinc_err_kept", 64'(err_sticky), 64'd1);
    wait_idle();
    clear_err();

    // Reset in the middle of a burst abandons it immediately.
    req_len[15:8] = 8'd3;
    @(posedge aclk); #1 req_valid = 3'b010;
    wait_grant();
    @(posedge aclk); #1 req_valid = '0;
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rready", 64'(m_axi_rready), 64'd0);
    chk("midrst_arvalid", 64'(m_axi_arvalid), 64'd0);
    @(posedge aclk); #3 aresetn = 1'b1;
    @(posedge aclk); #1 req_valid = 3'b111;
    @(negedge aclk);
    chk("post_rst_grant", 64'(req_ready), 64'b001);
    @(posedge aclk); #1 req_valid = '0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bfs_axi_read_arbiter.md
BFS_AXI_READ_ARBITER -- requirements
Module: bfs_axi_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of read requesters (row-pointer, column-index, frontier fetch).
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32: AXI address width.
REQ-003 SHALL have parameter AXI_DATA_WIDTH, default 64: AXI data width.
REQ-004 SHALL have ports:
- aclk  in  1  clock; one clock, all logic on rising edge.
- aresetn  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester burst request.
- req_addr  in  NUM_REQ*AXI_ADDR_WIDTH  packed start addresses, requester i at slice i.
- req_len  in  NUM_REQ*8  packed AXI arlen values (beats-1).
- req_ready  out  NUM_REQ  one-hot request-accept pulse.
- rsp_data  out  AXI_DATA_WIDTH  read data, broadcast to all requesters.
- rsp_last  out  1  last beat, broadcast.
- rsp_valid  out  NUM_REQ  one-hot beat-valid to the owning requester.
- rsp_ready  in  NUM_REQ  per-requester beat accept.
- m_axi_araddr, m_axi_arlen, m_axi_arvalid  out  AXI_ADDR_WIDTH/8/1  AR channel.
- m_axi_arready  in  1.
- m_axi_rdata, m_axi_rlast, m_axi_rresp, m_axi_rvalid  in  AXI_DATA_WIDTH/1/2/1  R channel.
- m_axi_rready  out  1.
- err_sticky  out  1  sticky error flag.
- err_clear  in  1  synchronous clear of err_sticky.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, ADDR, DATA; one burst outstanding at a time.
REQ-006 SHALL, in IDLE with any req_valid high, grant round-robin: search from (last_grant+1) mod NUM_REQ upward with wrap; winner g.
REQ-007 SHALL, on grant in cycle T, pulse req_ready[g] high for exactly cycle T, latch req_addr/req_len slice g, and enter ADDR at T+1.
REQ-008 SHALL hold m_axi_arvalid high in ADDR with m_axi_araddr/m_axi_arlen stable from the latch until m_axi_arvalid&m_axi_arready; then enter DATA.
REQ-009 SHALL, in DATA, drive m_axi_rready = rsp_ready[g], rsp_valid[g] = m_axi_rvalid, all other rsp_valid bits 0, rsp_data = m_axi_rdata and rsp_last = m_axi_rlast combinationally (zero-latency pass-through).
REQ-010 SHALL, on beat with m_axi_rvalid&m_axi_rready&m_axi_rlast, return to IDLE and set last_grant = g; a new grant is possible in the next cycle.
REQ-011 SHALL count accepted beats in an 8-bit counter cleared at grant; on the rlast beat set err_sticky if count != latched len.
REQ-012 SHALL set err_sticky on any accepted beat with m_axi_rresp != 2'b00.
REQ-013 SHALL, when err_clear and an error set coincide, keep err_sticky set.
REQ-014 SHALL keep m_axi_rready, rsp_valid at 0 outside DATA and m_axi_arvalid at 0 outside ADDR.
REQ-015 SHALL ignore requester deassertion of req_valid after acceptance; latched burst completes.
REQ-016 SHALL, with a single requester continuously requesting, grant it back-to-back (no idle penalty beyond the IDLE cycle).

Reset
REQ-017 SHALL, on aresetn low, asynchronously force state IDLE, last_grant = NUM_REQ-1 (requester 0 wins first), m_axi_arvalid 0, m_axi_rready 0, req_ready 0, rsp_valid 0, err_sticky 0, busy 0, beat counter 0, latched addr/len 0.
REQ-018 SHALL, on reset mid-burst, abandon the burst without draining; the system reset covers the interconnect.

Structure
REQ-019 SHALL place FSM state encodings and the OKAY response constant in the shared bfs package.
REQ-020 SHALL keep the round-robin pick as one combinational sub-module, bfs_rr_pick (inputs req vector and last_grant, output index and found).

Verification
REQ-021 SHALL check reset: after aresetn release, all outputs 0, first simultaneous request 3'b111 -> req_ready = 3'b001.
REQ-022 SHALL check fairness: req_valid held 3'b111 for 6 bursts -> grant order 0,1,2,0,1,2.
REQ-023 SHALL check AR hold: arready low 5 cycles -> araddr/arlen stable, arvalid high throughout, req 1 addr 0x1000 len 3 -> 4 beats routed only to rsp_valid[1].
REQ-024 SHALL check backpressure: rsp_ready[g] toggled -> m_axi_rready mirrors it, no beat lost or duplicated.
REQ-025 SHALL check errors: rresp=2'b10 on beat 2 -> err_sticky 1 until err_clear; rlast after 2 beats with len 3 -> err_sticky 1; err_clear coincident with error -> stays 1.
